// File: rtl/mux_nx1_stream_if.sv
// Stream mux bus: N_CH valid/ready producer channels in, one registered channel out.
// master drives the producer/consumer side, slave is the mux itself.
interface mux_nx1_stream_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// Registered N-to-1 valid/ready stream mux with static-select or round-robin grant.
// One-entry output register; EMPTY/FULL FSM allows back-to-back pop+push without bubbles.
module mux_nx1_stream #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_nx1_stream_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned IDX_W = SEL_W + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    out_ch_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [N_CH-1:0]     grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic [DATA_W-1:0]   gnt_data;
  logic                any_grant;
  logic [IDX_W-1:0]    idx_w;
  logic                load;
  logic                xfer;
  logic [N_CH-1:0]     in_ready_c;

  // Grant selection; the static path never matches an out-of-range sel
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    idx_w     = '0;
    if (!bus.mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant[i]  = 1'b1;
          gnt_idx   = SEL_W'(i);
          any_grant = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N_CH; k++) begin
        idx_w = IDX_W'(rr_ptr) + IDX_W'(k);
        if (idx_w >= IDX_W'(N_CH)) idx_w = idx_w - IDX_W'(N_CH);
        if (!any_grant && bus.in_valid[idx_w[SEL_W-1:0]]) begin
          grant[idx_w[SEL_W-1:0]] = 1'b1;
          gnt_idx   = idx_w[SEL_W-1:0];
          any_grant = 1'b1;
        end
      end
    end
  end

  // Data of the granted channel
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) gnt_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (bus.out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // FSM outputs; rst_n gates load so no producer sees ready while in reset
  always_comb begin
    load       = rst_n & ((state == EMPTY) | bus.out_ready);
    in_ready_c = load ? grant : '0;
    xfer       = load & any_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr     <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      out_data_q <= gnt_data;
      out_ch_q   <= gnt_idx;
      if (bus.mode) rr_ptr <= gnt_idx;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule
